uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Standalone UART receive deframer: samples the serial line, recovers 8-bit frames and reports data with error status.
- Programmable divisor, parity and stop-bit count. Config port names and encodings match uart_top, so it can sit on the far end of the uart_txd link as an independent receiver.
- Also serves as a checker/monitor endpoint on boards and in loopback benches.

Parameters:
- MIN_DIV, 4, smallest effective clocks-per-bit; baud_div values below this are treated as MIN_DIV.
- SYNC_STAGES, 2, flops in the uart_rxd synchroniser (legal values 2..3).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_div  input  16  clocks per bit
- parity_mode  input  2  0=none, 1=even, 2=odd, 3=treated as none
- stop_bits  input  1  0=one stop bit, 1=two stop bits
- uart_rxd  input  1  serial line, idle high
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle frame-complete pulse
- rx_error  output  1  rx_parity_err OR rx_frame_err, qualified by rx_valid
- rx_parity_err  output  1  parity mismatch, qualified by rx_valid
- rx_frame_err  output  1  stop bit sampled low, qualified by rx_valid
- rx_break  output  1  one-cycle pulse on break detection
- rx_busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
  - All outputs 0; synchroniser flops reset to 1; FSM in IDLE.
  - Reset asserted mid-frame aborts the frame with no rx_valid.
- Line conditioning: uart_rxd passes through SYNC_STAGES flops; all logic uses the synchronised value rxs.
- Configuration: div = max(baud_div, MIN_DIV). div, parity_mode and stop_bits are latched on start-edge detection; changes mid-frame have no effect.
- Bit timing:
  - 16-bit counter runs 0..div-1 per bit.
  - Sample point is counter == div/2 (floor).
  - Bit k (k=0 is the start bit) is sampled at E + k*div + div/2, where E is the cycle rxs is first seen low in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE→START on rxs falling (1→0).
  - START: sample high → false start, return to IDLE, no outputs, rx_busy drops. Sample low → DATA.
  - DATA: 8 samples, LSB first into a shift register. Then go to PARITY if parity_mode is 1 or 2, else STOP1.
  - PARITY: even mode requires XOR(data, p)==0; odd mode requires ==1; mismatch sets a parity-error flag.
  - STOP1: sample low sets frame error. Go to STOP2 if stop_bits=1, else complete.
  - STOP2: sampled and checked the same way as STOP1.
- Completion:
  - Occurs in the cycle after the last stop-bit sample.
  - rx_data loaded, rx_valid=1 for exactly one cycle, error outputs driven for that cycle only, then 0.
  - rx_data holds until the next completion.
  - FSM returns to IDLE immediately. The remaining half stop bit is not waited for, so back-to-back frames are accepted.
- Break: a frame error with data==0x00 (and parity bit 0 if enabled) is a break.
  - rx_valid fires with rx_frame_err=1 and rx_error=1, and rx_break pulses in the same cycle.
  - FSM then enters BRK_WAIT and stays until rxs is high, then goes to IDLE. No further frames or pulses while the line is held low.
- Frame error that is not a break: if the line is still low at completion, the next falling edge is not seen. The FSM waits in IDLE for the line to go high then low again.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is decided by a 2-of-3 majority of rxs at counter values div/2-1, div/2 and div/2+1. The decision is taken at div/2+1, so completion moves one cycle later.
- Undefined: single sample at div/2; no extra registers.

Test Plan:
- baud_div=16, parity 0, 1 stop; drive frame 0xA5 → exactly one rx_valid pulse, rx_data=0xA5, rx_error=0, rx_valid 1 cycle after the stop-bit sample (E+9*16+8+1).
- baud_div=16, parity 1; send 0x12 with parity bit forced to 1 → rx_valid with rx_parity_err=1, rx_error=1, rx_data=0x12. Repeat with parity 2 and the correct bit 1 → no error.
- stop_bits=1; send 0xDE with second stop bit low → rx_frame_err=1. Then 0xAD with correct framing → no error.
- baud_div=16; 4-cycle low glitch on an idle line → no rx_valid, rx_busy back to 0 by E+9.
- Line held low for 12 bit times → single rx_valid with rx_data=0x00, rx_frame_err=1, one rx_break pulse, no more pulses. After the line goes high, frame 0x55 is received cleanly.
- Assert rst_n low during the DATA bits of 0xFF → outputs 0 immediately. After release, next frame 0x3C is received correctly. baud_div=2 behaves identically to baud_div=4.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive deframer with programmable divisor, parity, stop bits and break detection.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the mid-bit point.
module uart_rx_deframer #(
  parameter int MIN_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_div,
  input  logic [1:0]  parity_mode,
  input  logic        stop_bits,
  input  logic        uart_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_error,
  output logic        rx_parity_err,
  output logic        rx_frame_err,
  output logic        rx_break,
  output logic        rx_busy
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP1    = 3'd4;
  localparam logic [2:0] STOP2    = 3'd5;
  localparam logic [2:0] BRK_WAIT = 3'd6;
  localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q, fall;
  logic [2:0]             state_q, state_d, bitn_q, bitn_d;
  logic [15:0]            cnt_q, cnt_d, div_q, div_d, half;
  logic [1:0]             par_q, par_d;
  logic                   stop2_q, stop2_d;
  logic [7:0]             shift_q, shift_d, rx_data_q, rx_data_d;
  logic                   pbit_q, pbit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                   rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d, rx_break_q, rx_break_d;
  logic                   sample, bit_val, par_en, ferr_now, is_break, last_stop;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign fall   = rxs_prev_q & ~rxs;
  assign half   = div_q >> 1;
  assign par_en = par_q[0] ^ par_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;
  assign sample  = cnt_q == half + 16'd1;
  assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) maj_q <= 2'b11;
    else if (cnt_q == half - 16'd1) maj_q[0] <= rxs;
    else if (cnt_q == half) maj_q[1] <= rxs;
  end
`else
  assign sample  = cnt_q == half;
  assign bit_val = rxs;
`endif

  assign ferr_now  = ferr_q | ~bit_val;
  assign last_stop = sample && (state_q == STOP2 || (state_q == STOP1 && !stop2_q));
  assign is_break  = ferr_now && shift_q == 8'h00 && !(par_en && pbit_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == IDLE || state_q == BRK_WAIT || cnt_q == div_q - 16'd1) ? 16'd0 : cnt_q + 16'd1;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    bitn_d     = bitn_q;
    shift_d    = shift_q;
    pbit_d     = pbit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ferr_d  = 1'b0;
    rx_break_d = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        cnt_d   = 16'd1;
        div_d   = baud_div < MIN_DIV_W ? MIN_DIV_W : baud_div;
        par_d   = parity_mode;
        stop2_d = stop_bits;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: if (sample) begin
        state_d = bit_val ? IDLE : DATA;
        bitn_d  = 3'd0;
      end
      DATA: if (sample) begin
        shift_d = {bit_val, shift_q[7:1]};
        bitn_d  = bitn_q + 3'd1;
        if (bitn_q == 3'd7) state_d = par_en ? PARITY : STOP1;
      end
      // par_q[1] is set only for odd mode, which is the required XOR result
      PARITY: if (sample) begin
        pbit_d  = bit_val;
        perr_d  = (^shift_q ^ bit_val) != par_q[1];
        state_d = STOP1;
      end
      STOP1: if (sample) begin
        ferr_d = ferr_now;
        if (stop2_q) state_d = STOP2;
      end
      STOP2: if (sample) ferr_d = ferr_now;
      BRK_WAIT: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (last_stop) begin
      state_d    = is_break ? BRK_WAIT : IDLE;
      rx_valid_d = 1'b1;
      rx_data_d  = shift_q;
      rx_perr_d  = perr_q;
      rx_ferr_d  = ferr_now;
      rx_break_d = is_break;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      div_q      <= MIN_DIV_W;
      par_q      <= 2'd0;
      stop2_q    <= 1'b0;
      bitn_q     <= 3'd0;
      shift_q    <= 8'h00;
      pbit_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
      pbit_q     <= pbit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_break_q <= rx_break_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_error      = rx_perr_q | rx_ferr_q;
  assign rx_break      = rx_break_q;
  assign rx_busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames with a scoreboard of expected completions checked by a monitor.
module tb_uart_rx_deframer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop_bits = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_error, rx_parity_err, rx_frame_err, rx_break, rx_busy;

  uart_rx_deframer dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .uart_rxd(uart_rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       br;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rx_break) check("break_has_valid", rx_valid, 1);
      if (rx_valid) begin
        check("valid_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rx_data", rx_data, e.d);
          check("rx_parity_err", rx_parity_err, e.pe);
          check("rx_frame_err", rx_frame_err, e.fe);
          check("rx_error", rx_error, e.pe | e.fe);
          check("rx_break", rx_break, e.br);
          check("valid_cycle", cyc, e.t);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Valid is expected one cycle after the last stop sample, two sync flops after the line edge.
  task automatic frame(input logic [7:0] d, input int dv, input logic hasp, input logic pb,
                       input logic two, input logic s2, input logic ep, input logic ef);
    exp_t e;
    int nb;
    nb = 10 + int'(hasp) + int'(two);
    e.d = d; e.pe = ep; e.fe = ef; e.br = 1'b0;
    e.t = cyc + 2 + (nb - 1) * dv + dv / 2 + 1;
    sb.push_back(e);
    drive(1'b0, dv);
    for (int i = 0; i < 8; i++) drive(d[i], dv);
    if (hasp) drive(pb, dv);
    drive(1'b1, dv);
    if (two) drive(s2, dv);
    uart_rxd = 1'b1;
  endtask

  initial begin
    exp_t e;
    int c0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_flags", {rx_valid, rx_error, rx_parity_err, rx_frame_err, rx_break}, 0);
    rst_n = 1'b1;
    drive(1'b1, 16);
    frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    parity_mode = 2'd1;
    frame(8'h12, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    parity_mode = 2'd2;
    frame(8'h12, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    parity_mode = 2'd0;
    stop_bits = 1'b1;
    frame(8'hDE, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16);
    frame(8'hAD, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    stop_bits = 1'b0;
    drive(1'b1, 16);
    c0 = cyc;
    drive(1'b0, 4);
    uart_rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy_high", rx_busy, 1);
    while (cyc < c0 + 11) @(negedge clk);
    check("glitch_busy_low", rx_busy, 0);
    drive(1'b1, 32);
    e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1; e.br = 1'b1;
    e.t = cyc + 2 + 9 * 16 + 8 + 1;
    sb.push_back(e);
    drive(1'b0, 12 * 16);
    drive(1'b1, 32);
    frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 48);
    check("mid_frame_busy", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_data", rx_data, 0);
    check("abort_busy", rx_busy, 0);
    check("abort_flags", {rx_valid, rx_error, rx_parity_err, rx_frame_err, rx_break}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16);
    baud_div = 16'd2;
    frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8);
    baud_div = 16'd4;
    frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
